// File: rtl/memory.sv
// rtl/memory.sv - calculator operand/operator store; MEMORY_DIGIT_GUARD_EN keeps the first four keyed digits
module memory (
  input  logic        clk,
  input  logic        clear_enable,
  input  logic [3:0]  num,
  input  logic [15:0] res,
  input  logic [1:0]  operator,
  input  logic        equ_enable,
  input  logic [1:0]  save_enable,
  input  logic        op_enable,
  output logic [15:0] save1,
  output logic [15:0] save2,
  output logic [3:0]  op_out
);

  localparam logic [1:0] SEL_SAVE1 = 2'b01;
  localparam logic [1:0] SEL_OP    = 2'b10;
  localparam logic [1:0] SEL_SAVE2 = 2'b11;
  localparam logic [2:0] CNT_FULL  = 3'd4;

  logic [15:0] save1_q, save1_d;
  logic [15:0] save2_q, save2_d;
  logic [2:0]  cnt1_q, cnt1_d;
  logic [2:0]  cnt2_q, cnt2_d;
  logic [3:0]  op_q, op_d;

  logic digit_valid;
  logic op_capture;

  // Whether a register with this digit count still takes a new digit.
  function automatic logic digit_accept(input logic [2:0] cnt);
`ifdef MEMORY_DIGIT_GUARD_EN
    return cnt < CNT_FULL;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [2:0] count_next(input logic [2:0] cnt);
    return (cnt >= CNT_FULL) ? CNT_FULL : cnt + 3'd1;
  endfunction

  function automatic logic [3:0] op_onehot(input logic [1:0] code);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[code] = 1'b1;
    return oh;
  endfunction

  assign digit_valid = (num <= 4'd9);
  assign op_capture  = (save_enable == SEL_OP) || op_enable;

  // Clear is applied in the register process; equals outranks any keyed action.
  always_comb begin
    save1_d = save1_q;
    save2_d = save2_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    op_d    = op_q;
    if (equ_enable) begin
      save1_d = res;
      cnt1_d  = CNT_FULL;
      save2_d = 16'h0000;
      cnt2_d  = 3'd0;
      op_d    = 4'b0000;
    end else if (op_capture) begin
      op_d = op_onehot(operator);
    end else if (digit_valid && save_enable == SEL_SAVE1 && digit_accept(cnt1_q)) begin
      save1_d = {save1_q[11:0], num};
      cnt1_d  = count_next(cnt1_q);
    end else if (digit_valid && save_enable == SEL_SAVE2 && digit_accept(cnt2_q)) begin
      save2_d = {save2_q[11:0], num};
      cnt2_d  = count_next(cnt2_q);
    end
  end

  always_ff @(posedge clk) begin
    if (clear_enable) begin
      save1_q <= 16'h0000;
      save2_q <= 16'h0000;
      cnt1_q  <= 3'd0;
      cnt2_q  <= 3'd0;
      op_q    <= 4'b0000;
    end else begin
      save1_q <= save1_d;
      save2_q <= save2_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      op_q    <= op_d;
    end
  end

  assign save1  = save1_q;
  assign save2  = save2_q;
  assign op_out = op_q;

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - self-checking bench for memory against an arithmetic reference model
module tb_memory;
  logic        clk = 1'b0;
  logic        clear_enable = 1'b0;
  logic [3:0]  num = '0;
  logic [15:0] res = '0;
  logic [1:0]  operator = '0;
  logic        equ_enable = 1'b0;
  logic [1:0]  save_enable = '0;
  logic        op_enable = 1'b0;
  logic [15:0] save1, save2;
  logic [3:0]  op_out;

  int n_cmp = 0;
  int n_err = 0;

  int m_s1, m_s2, m_c1, m_c2, m_op;

  memory dut (
    .clk(clk), .clear_enable(clear_enable), .num(num), .res(res),
    .operator(operator), .equ_enable(equ_enable), .save_enable(save_enable),
    .op_enable(op_enable), .save1(save1), .save2(save2), .op_out(op_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void key_digit(inout int s, inout int c, input int d);
`ifdef MEMORY_DIGIT_GUARD_EN
    if (c < 4) begin
      s = (s * 16 + d) % 65536;
      c = c + 1;
    end
`else
    s = (s * 16 + d) % 65536;
    c = (c < 4) ? c + 1 : 4;
`endif
  endfunction

  // Apply one cycle of inputs and advance the reference model by the same step.
  task automatic step(input bit clr, input bit equ, input int se, input bit ope,
                      input int n, input int opr, input int r);
    @(negedge clk);
    clear_enable = clr; equ_enable = equ; save_enable = 2'(se); op_enable = ope;
    num = 4'(n); operator = 2'(opr); res = 16'(r);
    if (clr) begin
      m_s1 = 0; m_s2 = 0; m_c1 = 0; m_c2 = 0; m_op = 0;
    end else if (equ) begin
      m_s1 = r; m_c1 = 4; m_s2 = 0; m_c2 = 0; m_op = 0;
    end else if (se == 2 || ope) begin
      m_op = 1 << opr;
    end else if (se == 1 && n <= 9) begin
      key_digit(m_s1, m_c1, n);
    end else if (se == 3 && n <= 9) begin
      key_digit(m_s2, m_c2, n);
    end
    @(posedge clk);
    #1;
    clear_enable = 0; equ_enable = 0; save_enable = 0; op_enable = 0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (save1 !== 16'h0000) begin n_err++; $display("FAIL reset_save1 got %h want 0000", save1); end
    n_cmp++; if (save2 !== 16'h0000) begin n_err++; $display("FAIL reset_save2 got %h want 0000", save2); end
    n_cmp++; if (op_out !== 4'b0000) begin n_err++; $display("FAIL reset_op got %b want 0000", op_out); end
  endtask

  task automatic test_digit_entry();
    logic [15:0] exp_tab [4];
    logic [15:0] exp5, exp6;
    exp_tab[0] = 16'h0001; exp_tab[1] = 16'h0012; exp_tab[2] = 16'h0123; exp_tab[3] = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, i + 1, 0, 0);
      n_cmp++; if (save1 !== exp_tab[i]) begin n_err++; $display("FAIL digit_save1[%0d] got %h want %h", i, save1, exp_tab[i]); end
    end
    n_cmp++; if (save2 !== 16'h0000 || op_out !== 4'b0000) begin n_err++; $display("FAIL digit_others got %h/%b want 0000/0000", save2, op_out); end
`ifdef MEMORY_DIGIT_GUARD_EN
    exp5 = 16'h1234; exp6 = 16'h1234;
`else
    exp5 = 16'h2345; exp6 = 16'h3456;
`endif
    step(0, 0, 1, 0, 5, 0, 0);
    n_cmp++; if (save1 !== exp5) begin n_err++; $display("FAIL digit_fifth got %h want %h", save1, exp5); end
    step(0, 0, 1, 0, 6, 0, 0);
    n_cmp++; if (save1 !== exp6) begin n_err++; $display("FAIL digit_sixth got %h want %h", save1, exp6); end
  endtask

  task automatic test_save2_operator();
    step(0, 0, 3, 0, 5, 0, 0);
    n_cmp++; if (save2 !== 16'h0005) begin n_err++; $display("FAIL save2_digit got %h want 0005", save2); end
    step(0, 0, 2, 0, 0, 2, 0);
    n_cmp++; if (op_out !== 4'b0100) begin n_err++; $display("FAIL op_mul got %b want 0100", op_out); end
    step(0, 0, 0, 1, 0, 3, 0);
    n_cmp++; if (op_out !== 4'b1000) begin n_err++; $display("FAIL op_div_overwrite got %b want 1000", op_out); end
    step(0, 0, 0, 0, 7, 1, 16'hFFFF);
    n_cmp++; if (op_out !== 4'b1000 || save2 !== 16'h0005) begin n_err++; $display("FAIL hold got %b/%h want 1000/0005", op_out, save2); end
  endtask

  task automatic test_equals();
    step(0, 1, 0, 0, 0, 0, 16'h9ABC);
    n_cmp++; if (save1 !== 16'h9ABC) begin n_err++; $display("FAIL equ_save1 got %h want 9abc", save1); end
    n_cmp++; if (save2 !== 16'h0000) begin n_err++; $display("FAIL equ_save2 got %h want 0000", save2); end
    n_cmp++; if (op_out !== 4'b0000) begin n_err++; $display("FAIL equ_op got %b want 0000", op_out); end
  endtask

  task automatic test_invalid_digit();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 8, 0, 0);
    step(0, 0, 1, 0, 4'hC, 0, 0);
    n_cmp++; if (save1 !== 16'h0008) begin n_err++; $display("FAIL invalid_digit got %h want 0008", save1); end
    step(0, 0, 1, 0, 2, 0, 0);
    n_cmp++; if (save1 !== 16'h0082) begin n_err++; $display("FAIL after_invalid got %h want 0082", save1); end
  endtask

  task automatic test_clear_override();
    step(0, 0, 2, 0, 0, 1, 0);
    step(1, 1, 1, 1, 7, 2, 16'h5555);
    n_cmp++; if (save1 !== 16'h0000 || save2 !== 16'h0000 || op_out !== 4'b0000) begin
      n_err++; $display("FAIL clear_override got %h/%h/%b want 0000/0000/0000", save1, save2, op_out);
    end
  endtask

  task automatic test_random();
    int kind, se, n;
    bit ope;
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 99);
      n = $urandom_range(0, 15);
      se = $urandom_range(0, 3);
      ope = (se == 0 || se == 2) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      if (kind < 3)
        step(1, 0, se, ope, n, $urandom_range(0, 3), $urandom_range(0, 65535));
      else if (kind < 8)
        step(0, 1, se, ope, n, $urandom_range(0, 3), $urandom_range(0, 65535));
      else
        step(0, 0, se, ope, n, $urandom_range(0, 3), $urandom_range(0, 65535));
      n_cmp++;
      if (save1 !== 16'(m_s1) || save2 !== 16'(m_s2) || op_out !== 4'(m_op)) begin
        n_err++;
        $display("FAIL random[%0d] got %h/%h/%b want %h/%h/%b", i, save1, save2, op_out,
                 16'(m_s1), 16'(m_s2), 4'(m_op));
      end
    end
  endtask

  initial begin
    test_reset();
    test_digit_entry();
    test_save2_operator();
    test_equals();
    test_invalid_digit();
    test_clear_override();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: clear_enable  input  1  reset; synchronous, active-high; clears all stored state.
REQ-003 SHALL have port: num  input  4  BCD digit being keyed; values 10-15 are invalid.
REQ-004 SHALL have port: res  input  16  result word from the ALU, 4-digit BCD.
REQ-005 SHALL have port: operator  input  2  operator code; 00 add, 01 sub, 10 mul, 11 div.
REQ-006 SHALL have port: equ_enable  input  1  equals pressed; load res into save1.
REQ-007 SHALL have port: save_enable  input  2  action select; 00 idle, 01 digit to save1, 11 digit to save2, 10 capture operator.
REQ-008 SHALL have port: op_enable  input  1  alternate operator-capture strobe.
REQ-009 SHALL have port: save1  output  16  first operand register, 4-digit BCD, digit 0 in [3:0].
REQ-010 SHALL have port: save2  output  16  second operand register, same format.
REQ-011 SHALL have port: op_out  output  4  stored operator, one-hot; 0000 = none.

Function
REQ-012 SHALL register all outputs directly; each update is visible one clk edge after the controlling inputs are sampled.
REQ-013 SHALL apply one action per edge, in priority order: clear_enable, then equ_enable, then save_enable/op_enable.
REQ-014 SHALL, on save_enable=01 with valid num, set save1 <= {save1[11:0], num} and increment a 3-bit digit count for save1.
REQ-015 SHALL, on save_enable=11 with valid num, shift num into save2 the same way, with its own digit count.
REQ-016 SHALL ignore digit entry when num > 9: register and count unchanged.
REQ-017 SHALL enter one digit per clk edge while save_enable is held (no edge detection).
REQ-018 SHALL, on save_enable=10 or op_enable=1, load op_out with the one-hot code: 00->0001, 01->0010, 10->0100, 11->1000.
REQ-019 SHALL let a later operator capture overwrite the earlier one.
REQ-020 SHALL, on equ_enable=1, load save1 <= res, set the save1 count to 4, clear save2 and its count, and clear op_out to 0000.
REQ-021 SHALL hold all state when no action is asserted.

Reset
REQ-022 SHALL, on clear_enable=1 at a clk edge, set save1=0000h, save2=0000h, op_out=0000 and both digit counts to 0, regardless of the other inputs.
REQ-023 SHALL let clear_enable override a digit entry, operator capture or equals in the same cycle.
REQ-024 SHALL leave outputs undefined before the first clear; the bench SHALL assert clear_enable first.

Configuration
REQ-025 SHALL support macro MEMORY_DIGIT_GUARD_EN.
REQ-026 With MEMORY_DIGIT_GUARD_EN defined: digit entry into a register whose count is 4 SHALL be ignored, so the first four digits are kept.
REQ-027 Without MEMORY_DIGIT_GUARD_EN: digit entry SHALL always shift; the most significant digit is discarded and the count saturates at 4.

Verification
REQ-028 Clear, then save_enable=01 for one cycle each with num=1,2,3,4 -> save1 = 0001h, 0012h, 0123h, 1234h; save2=0000h; op_out=0000.
REQ-029 Continue with num=5 then 6 -> guard enabled: save1 stays 1234h; guard disabled: 2345h then 3456h.
REQ-030 save_enable=11, num=5 for one cycle -> save2=0005h; then save_enable=10, operator=10 -> op_out=0100; then op_enable=1, operator=11 -> op_out=1000.
REQ-031 equ_enable=1, res=9ABCh with save2 nonzero -> save1=9ABCh, save2=0000h, op_out=0000.
REQ-032 num=4'hC with save_enable=01 -> save1 and count unchanged.
REQ-033 clear_enable=1 together with save_enable=01, num=7 -> save1=0000h, save2=0000h, op_out=0000.
